tick_timer: RTL and testbench

Programmable down-count timer that sits directly downstream of the counter block. It consumes the counter's overflow output as a synchronous tick input and does not use it as a clock. On each detected tick it decrements a loaded value, then signals expiry, either once (one-shot) or repeatedly with automatic reload (periodic). It replaces clock-cascading of counter stages with a single-clock-domain prescaled timer.

---
 rtl/tick_timer.sv | 109 ++++++++++
 tb/tb_tick_timer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// Programmable down-count timer driven by an upstream overflow level. Each rising
// edge of tick_in decrements the running count; expiry is one-shot or auto-reload.
module tick_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire,
  output logic             expired_flag
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;
  logic             tick_q;
  logic             busy_q;
  logic             expire_q;
  logic             flag_q;

  logic             tick_rise;
  logic             load_ok;
  logic             last_tick;

  assign tick_rise = tick_in & ~tick_q;
  assign load_ok   = (load_val != '0);
  assign last_tick = (count_q == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      expire_q <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      tick_q   <= tick_in;
      expire_q <= 1'b0;
      // Clear first so that an expiry later in this block overrides it.
      if (clr_flag) flag_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start && load_ok) begin
            count_q  <= load_val;
            reload_q <= load_val;
            mode_q   <= periodic;
            state_q  <= RUN;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            count_q <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (start) begin
            if (load_ok) begin
              count_q  <= load_val;
              reload_q <= load_val;
              mode_q   <= periodic;
            end else begin
              count_q <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (tick_rise) begin
            if (!last_tick) begin
              count_q <= count_q - WIDTH'(1);
            end else begin
              expire_q <= 1'b1;
              flag_q   <= 1'b1;
              if (mode_q) begin
                count_q <= reload_q;
              end else begin
                count_q <= '0;
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count        = count_q;
  assign busy         = busy_q;
  assign expire       = expire_q;
  assign expired_flag = flag_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed table, corner sequences, and
// randomized traffic compared against a cycle-level behavioural model.
module tb_tick_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, tick_in, start, stop, periodic, clr_flag;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy, expire, expired_flag;

  tick_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .periodic(periodic), .load_val(load_val), .clr_flag(clr_flag),
    .count(count), .busy(busy), .expire(expire), .expired_flag(expired_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_expire = 0;
  int n_busy_low = 0;

  // behavioural reference state
  bit m_run, m_per, m_flag, m_exp, m_prev;
  int m_cnt, m_rel;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise;
    if (!rst) begin
      m_run = 0; m_per = 0; m_flag = 0; m_exp = 0; m_prev = 0; m_cnt = 0; m_rel = 0;
    end else begin
      rise   = tick_in && !m_prev;
      m_prev = tick_in;
      m_exp  = 0;
      if (clr_flag) m_flag = 0;
      if (m_run && stop) begin
        m_run = 0; m_cnt = 0;
      end else if (start) begin
        if (load_val != 0) begin
          m_run = 1; m_cnt = load_val; m_rel = load_val; m_per = periodic;
        end else if (m_run) begin
          m_run = 0; m_cnt = 0;
        end
      end else if (m_run && rise) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_exp = 1; m_flag = 1;
          if (m_per) m_cnt = m_rel;
          else m_run = 0;
        end
      end
    end
  endtask

  // One clock: drive, let the edge happen, then compare DUT to model.
  task automatic cyc(input logic r, input logic t, input logic s, input logic sp,
                     input logic p, input logic [W-1:0] lv, input logic c);
    rst = r; tick_in = t; start = s; stop = sp; periodic = p; load_val = lv; clr_flag = c;
    @(posedge clk);
    model_step();
    #1;
    chk("count", count, m_cnt);
    chk("busy", busy, m_run);
    chk("expire", expire, m_exp);
    chk("flag", expired_flag, m_flag);
    if (expire) n_expire++;
    if (!busy) n_busy_low++;
  endtask

  task automatic tick(input logic t);
    cyc(1, t, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic r, t, s, sp, p, c;
    logic [W-1:0] lv;
    int e_cnt;
    logic e_busy, e_exp, e_flag;
  } vec_t;

  vec_t tbl[20];

  initial begin
    //            r  t  s  sp p  c  lv  cnt busy exp flag
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0};
    tbl[2]  = '{1, 0, 1, 0, 0, 0, 3,  3,  1,  0,  0};
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0,  2,  1,  0,  0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 0,  2,  1,  0,  0};
    tbl[5]  = '{1, 1, 0, 0, 0, 0, 0,  1,  1,  0,  0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 0,  1,  1,  0,  0};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 0,  1,  1,  0,  0};
    tbl[8]  = '{1, 1, 0, 0, 0, 1, 0,  0,  0,  1,  1};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0,  0,  0,  0,  1};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 0,  0,  0,  0,  0};
    tbl[11] = '{1, 1, 0, 0, 0, 0, 0,  0,  0,  0,  0};
    tbl[12] = '{1, 0, 1, 0, 0, 0, 0,  0,  0,  0,  0};
    tbl[13] = '{1, 0, 1, 0, 1, 0, 2,  2,  1,  0,  0};
    tbl[14] = '{1, 1, 0, 0, 0, 0, 0,  1,  1,  0,  0};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 0,  1,  1,  0,  0};
    tbl[16] = '{1, 1, 0, 0, 0, 0, 0,  2,  1,  1,  1};
    tbl[17] = '{1, 0, 0, 0, 0, 0, 0,  2,  1,  0,  1};
    tbl[18] = '{1, 1, 0, 1, 0, 0, 0,  0,  0,  0,  1};
    tbl[19] = '{1, 0, 0, 0, 0, 0, 0,  0,  0,  0,  1};

    rst = 0; tick_in = 0; start = 0; stop = 0; periodic = 0; load_val = 0; clr_flag = 0;
    @(negedge clk);

    // Directed table against hand-derived constants
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].sp, tbl[i].p, tbl[i].lv, tbl[i].c);
      chk($sformatf("tbl%0d.count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d.busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d.expire", i), expire, tbl[i].e_exp);
      chk($sformatf("tbl%0d.flag", i), expired_flag, tbl[i].e_flag);
    end

    // One-shot load 3, 1-cycle ticks every 8 cycles
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 0, 3, 0);
    n_expire = 0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) begin
        tick(j == 0);
        if (expire) chk("oneshot.busy_at_expire", busy, 0);
      end
    chk("oneshot.expires", n_expire, 1);
    chk("oneshot.flag_held", expired_flag, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("oneshot.flag_cleared", expired_flag, 0);

    // Periodic load 2, six ticks
    cyc(1, 0, 1, 0, 1, 2, 0);
    n_expire = 0; n_busy_low = 0;
    for (int k = 0; k < 6; k++) begin tick(1); tick(0); tick(0); end
    chk("periodic.expires", n_expire, 3);
    chk("periodic.busy_low_cycles", n_busy_low, 0);
    chk("periodic.count", count, 2);
    cyc(1, 0, 0, 1, 0, 0, 1);

    // Held-high ticks count once each
    cyc(1, 0, 1, 0, 0, 4, 0);
    n_expire = 0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 20; j++) tick(1);
      tick(0);
      if (k < 3) chk("held.count", count, 3 - k);
    end
    chk("held.expires", n_expire, 1);
    chk("held.busy", busy, 0);

    // Stop on the 2nd tick edge; then zero-load start is ignored
    cyc(1, 0, 1, 0, 0, 5, 1);
    tick(1); tick(0);
    n_expire = 0;
    cyc(1, 1, 0, 1, 0, 0, 0);
    chk("stop.count", count, 0);
    chk("stop.busy", busy, 0);
    chk("stop.expire", n_expire, 0);
    chk("stop.flag", expired_flag, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk("zero_start.busy", busy, 0);

    // Reset mid periodic run with tick high across release
    cyc(1, 0, 1, 0, 1, 1, 0);
    tick(1); tick(0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("rst.count", count, 0);
    chk("rst.busy", busy, 0);
    chk("rst.flag", expired_flag, 0);
    n_expire = 0;
    tick(1); tick(1);
    cyc(1, 1, 1, 0, 0, 1, 0);
    chk("rst.restart_count", count, 1);
    tick(1); tick(1);
    chk("rst.held_not_tick", n_expire, 0);
    tick(0); tick(1); tick(0);
    chk("rst.single_expire", n_expire, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] lv;
      lv = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
      cyc($urandom_range(0, 199) != 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 29) == 0,
          1'($urandom),
          lv,
          $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
